// File: rtl/rf_write_arbiter_if.sv
// Write-back bus between the ALU/LSU requesters, the register-file write port
// and the forwarding taps of rf_write_arbiter.
interface rf_write_arbiter_if #(
   parameter int unsigned ADDRESS_WIDTH = 5,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned CNT_WIDTH     = 16
);
   logic                     wb0_valid_i;
   logic [ADDRESS_WIDTH-1:0] wb0_addr_i;
   logic [DATA_WIDTH-1:0]    wb0_data_i;
   logic                     wb0_ready_o;
   logic                     wb1_valid_i;
   logic [ADDRESS_WIDTH-1:0] wb1_addr_i;
   logic [DATA_WIDTH-1:0]    wb1_data_i;
   logic                     wb1_ready_o;
   logic                     rf_we_o;
   logic [ADDRESS_WIDTH-1:0] rf_waddr_o;
   logic [DATA_WIDTH-1:0]    rf_wdata_o;
   logic [ADDRESS_WIDTH-1:0] raddr1_i;
   logic [ADDRESS_WIDTH-1:0] raddr2_i;
   logic                     fwd1_hit_o;
   logic                     fwd2_hit_o;
   logic [DATA_WIDTH-1:0]    fwd1_data_o;
   logic [DATA_WIDTH-1:0]    fwd2_data_o;
   logic [CNT_WIDTH-1:0]     conflict_cnt_o;

   modport slave (
      input  wb0_valid_i, wb0_addr_i, wb0_data_i,
      input  wb1_valid_i, wb1_addr_i, wb1_data_i,
      input  raddr1_i, raddr2_i,
      output wb0_ready_o, wb1_ready_o,
      output rf_we_o, rf_waddr_o, rf_wdata_o,
      output fwd1_hit_o, fwd2_hit_o, fwd1_data_o, fwd2_data_o,
      output conflict_cnt_o
   );

   modport master (
      output wb0_valid_i, wb0_addr_i, wb0_data_i,
      output wb1_valid_i, wb1_addr_i, wb1_data_i,
      output raddr1_i, raddr2_i,
      input  wb0_ready_o, wb1_ready_o,
      input  rf_we_o, rf_waddr_o, rf_wdata_o,
      input  fwd1_hit_o, fwd2_hit_o, fwd1_data_o, fwd2_data_o,
      input  conflict_cnt_o
   );
endinterface

// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter with registered write port and forwarding.
// Define RF_ARB_ROUND_ROBIN_EN for round-robin conflict resolution; default is fixed priority to requester 0.
module rf_write_arbiter #(
   parameter int unsigned ADDRESS_WIDTH = 5,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned CNT_WIDTH     = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   rf_write_arbiter_if.slave bus
);
   logic                     w_both;
   logic                     w_gnt0;
   logic                     w_gnt1;
   logic                     w_xfer;
   logic [ADDRESS_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0]    w_data;

   logic                     r_we;
   logic [ADDRESS_WIDTH-1:0] r_waddr;
   logic [DATA_WIDTH-1:0]    r_wdata;
   logic [CNT_WIDTH-1:0]     r_cnt;

   assign w_both = bus.wb0_valid_i & bus.wb1_valid_i;

`ifdef RF_ARB_ROUND_ROBIN_EN
   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   logic r_last_grant;

   // On conflict, requester 0 wins only when requester 1 was served last.
   assign w_gnt0 = bus.wb0_valid_i & (~bus.wb1_valid_i | (r_last_grant == REQ1));
   assign w_gnt1 = bus.wb1_valid_i & ~w_gnt0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_last_grant <= REQ1;
      end else if (w_gnt1) begin
         r_last_grant <= REQ1;
      end else if (w_gnt0) begin
         r_last_grant <= REQ0;
      end
   end
`else
   assign w_gnt0 = bus.wb0_valid_i;
   assign w_gnt1 = bus.wb1_valid_i & ~bus.wb0_valid_i;
`endif

   assign w_xfer = w_gnt0 | w_gnt1;
   assign w_addr = w_gnt1 ? bus.wb1_addr_i : bus.wb0_addr_i;
   assign w_data = w_gnt1 ? bus.wb1_data_i : bus.wb0_data_i;

   assign bus.wb0_ready_o = w_gnt0 & rst_ni;
   assign bus.wb1_ready_o = w_gnt1 & rst_ni;

   // Index 0 is accepted but never written; address and data still load.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else if (w_xfer) begin
         r_we    <= (w_addr != '0);
         r_waddr <= w_addr;
         r_wdata <= w_data;
      end else begin
         r_we    <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else if (w_both && (r_cnt != '1)) begin
         r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
   end

   assign bus.rf_we_o        = r_we;
   assign bus.rf_waddr_o     = r_waddr;
   assign bus.rf_wdata_o     = r_wdata;
   assign bus.conflict_cnt_o = r_cnt;

   assign bus.fwd1_hit_o  = r_we & (r_waddr == bus.raddr1_i) & (bus.raddr1_i != '0);
   assign bus.fwd2_hit_o  = r_we & (r_waddr == bus.raddr2_i) & (bus.raddr2_i != '0);
   assign bus.fwd1_data_o = r_wdata;
   assign bus.fwd2_data_o = r_wdata;
endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 5, SHALL set the register-index width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the write-data width.
REQ-003 Parameter CNT_WIDTH, default 16, SHALL set the conflict-counter width.
REQ-004 Design SHALL use one clock, clk_i; reset rst_ni SHALL be asynchronous and active-low.
REQ-005 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 wb0_valid_i / wb1_valid_i  input  1 each  requester 0 (ALU) / requester 1 (LSU) write request.
REQ-008 wb0_addr_i / wb1_addr_i  input  ADDRESS_WIDTH each  destination register index.
REQ-009 wb0_data_i / wb1_data_i  input  DATA_WIDTH each  write data.
REQ-010 wb0_ready_o / wb1_ready_o  output  1 each  grant; transfer occurs when valid and ready are both high.
REQ-011 rf_we_o  output  1  registered write enable to the register file write port.
REQ-012 rf_waddr_o  output  ADDRESS_WIDTH  registered write index.
REQ-013 rf_wdata_o  output  DATA_WIDTH  registered write data.
REQ-014 raddr1_i / raddr2_i  input  ADDRESS_WIDTH each  current register file read indices.
REQ-015 fwd1_hit_o / fwd2_hit_o  output  1 each  pending write matches the read index.
REQ-016 fwd1_data_o / fwd2_data_o  output  DATA_WIDTH each  forwarded data (rf_wdata_o).
REQ-017 conflict_cnt_o  output  CNT_WIDTH  count of cycles where both requesters were valid.

Function
REQ-018 At most one readyX_o SHALL be high per cycle; readyX_o SHALL be low whenever validX_i is low (combinational from valids and grant state).
REQ-019 Single valid requester SHALL be granted in the same cycle.
REQ-020 With both valid, arbitration SHALL follow REQ-033/REQ-034; the loser holds valid, addr and data stable until granted.
REQ-021 On a transfer, rf_we_o, rf_waddr_o and rf_wdata_o SHALL be loaded at the next edge (1-cycle latency); the register file commits at the following edge.
REQ-022 A transfer with addr 0 SHALL be accepted (ready high) but SHALL load rf_we_o=0.
REQ-023 A cycle with no transfer SHALL load rf_we_o=0; rf_waddr_o and rf_wdata_o SHALL hold.
REQ-024 fwdN_hit_o SHALL be high iff rf_we_o=1 and rf_waddr_o==raddrN_i and raddrN_i!=0; fwdN_data_o SHALL equal rf_wdata_o at all times.
REQ-025 The output stage SHALL never stall: back-to-back transfers every cycle SHALL be sustained.
REQ-026 Both requesters targeting the same index SHALL be serialized in grant order; later grant's data is final.
REQ-027 conflict_cnt_o SHALL increment by 1 on every cycle with both valids high and SHALL saturate at all-ones.
REQ-028 Register last_grant SHALL record the requester of the most recent transfer, unchanged on cycles without a transfer.

Reset
REQ-029 While rst_ni=0: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, conflict_cnt_o=0, last_grant=1, fwd hits=0.
REQ-030 Reset asserted mid-operation SHALL clear all state immediately; a write loaded but not yet committed SHALL be discarded.
REQ-031 readyX_o SHALL be low while rst_ni=0.
REQ-032 After rst_ni deasserts, first transfer SHALL be possible on the first rising edge.

Configuration
REQ-033 With macro RF_ARB_ROUND_ROBIN_EN defined, on conflict the requester not equal to last_grant SHALL be granted.
REQ-034 Without RF_ARB_ROUND_ROBIN_EN, on conflict requester 0 SHALL always win; last_grant and its logic SHALL be absent.

Verification
REQ-035 Reset, wb0 valid addr=5 data=0xDEADBEEF -> ready0=1 same cycle; next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF.
REQ-036 Both valid 4 cycles (addr 3/7), RR enabled -> grants 0,1,0,1; conflict_cnt_o=4; without macro -> grants 0,0,0,0 and ready1 stays low.
REQ-037 wb1 valid addr=0 data=0x1234 -> ready1=1; next cycle rf_we_o=0.
REQ-038 Transfer addr=9 data=0xA5A5A5A5, next cycle raddr1_i=9, raddr2_i=4 -> fwd1_hit_o=1, fwd1_data_o=0xA5A5A5A5, fwd2_hit_o=0.
REQ-039 rst_ni pulsed low the cycle rf_we_o=1 -> rf_we_o=0 immediately, conflict_cnt_o=0, no write committed.
REQ-040 Force 2^CNT_WIDTH+3 conflict cycles -> conflict_cnt_o holds all-ones.
